// File: rtl/timer_alarm_pkg.sv
// Shared definitions for the timer alarm block: count width, status width
// and the alarm FSM state encoding (visible to software via ALARM_STATE).
package timer_alarm_pkg;
    localparam int TIMER_CNT_W   = 64;
    localparam int ALARM_STATE_W = 2;

    typedef enum logic [ALARM_STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_FIRED = 2'd2
    } alarm_state_e;
endpackage

// File: rtl/timer_alarm_cmp.sv
// Combinational wrap-safe compare plus the periodic reload adder.
//   i_count    : live 64-bit timer count
//   i_cmp      : current compare value
//   i_period   : reload increment, zero-extended
//   o_match    : count has reached or passed i_cmp (within half the range)
//   o_next_cmp : i_cmp + period, mod 2^64
module timer_alarm_cmp
    import timer_alarm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [TIMER_CNT_W-1:0] i_count,
    input  logic [TIMER_CNT_W-1:0] i_cmp,
    input  logic [DATA_W-1:0]      i_period,
    output logic                   o_match,
    output logic [TIMER_CNT_W-1:0] o_next_cmp
);
    logic [TIMER_CNT_W-1:0] w_diff;

    // A non-negative modular difference means "reached or passed", which
    // tolerates skipped counts and the 2^64 wrap.
    assign w_diff     = i_count - i_cmp;
    assign o_match    = ~w_diff[TIMER_CNT_W-1];
    assign o_next_cmp = i_cmp + {{(TIMER_CNT_W-DATA_W){1'b0}}, i_period};
endmodule

// File: rtl/timer_alarm.sv
// Alarm/compare unit watching the free-running 64-bit timer count.
//   TIMER_VALUE            : live count from the timer core
//   ALARM_ENABLE           : level, 0 disarms and clears IRQ/MISSED
//   ALARM_PERIODIC/PERIOD  : auto-reload mode and its increment
//   ALARM_CMP_LOW(_WEN)    : low half into shadow register
//   ALARM_CMP_HIGH(_WEN)   : commits {HIGH, shadow_low} atomically
//   ALARM_ACK              : clears IRQ and MISSED
//   ALARM_IRQ/MISSED       : latched interrupt / sticky overrun flag
//   ALARM_FIRE_CNT         : saturating fire count since last commit
//   ALARM_STATE            : FSM state for status reads
module timer_alarm
    import timer_alarm_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2*DATA_W-1:0]      TIMER_VALUE,
    input  logic                     ALARM_ENABLE,
    input  logic                     ALARM_PERIODIC,
    input  logic [DATA_W-1:0]        ALARM_CMP_LOW,
    input  logic                     ALARM_CMP_LOW_WEN,
    input  logic [DATA_W-1:0]        ALARM_CMP_HIGH,
    input  logic                     ALARM_CMP_HIGH_WEN,
    input  logic [DATA_W-1:0]        ALARM_PERIOD,
    input  logic                     ALARM_ACK,
    output logic                     ALARM_IRQ,
    output logic                     ALARM_MISSED,
    output logic [DATA_W-1:0]        ALARM_FIRE_CNT,
    output logic [ALARM_STATE_W-1:0] ALARM_STATE
);
    logic [DATA_W-1:0]      r_shadow_low, w_shadow_nxt, w_low_eff;
    logic [TIMER_CNT_W-1:0] r_cmp, w_cmp_nxt, w_reload_cmp;
    logic                   r_cmp_valid, w_valid_nxt;
    alarm_state_e           r_state, w_state_nxt;
    logic                   r_irq, w_irq_nxt;
    logic                   r_missed, w_missed_nxt;
    logic [DATA_W-1:0]      r_fire_cnt, w_cnt_nxt;
    logic                   w_match, w_fire, w_reload;

    timer_alarm_cmp #(.DATA_W(DATA_W)) u_cmp (
        .i_count    (TIMER_VALUE),
        .i_cmp      (r_cmp),
        .i_period   (ALARM_PERIOD),
        .o_match    (w_match),
        .o_next_cmp (w_reload_cmp)
    );

    // A LOW strobe in the same cycle as HIGH must land in the commit.
    assign w_low_eff = ALARM_CMP_LOW_WEN ? ALARM_CMP_LOW : r_shadow_low;
    // PERIOD=0 would re-fire forever on the same cmp, so it behaves one-shot.
    assign w_reload  = ALARM_PERIODIC && (ALARM_PERIOD != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_low <= '0;
            r_cmp        <= '0;
            r_cmp_valid  <= 1'b0;
            r_state      <= ST_IDLE;
            r_irq        <= 1'b0;
            r_missed     <= 1'b0;
            r_fire_cnt   <= '0;
        end else begin
            r_shadow_low <= w_shadow_nxt;
            r_cmp        <= w_cmp_nxt;
            r_cmp_valid  <= w_valid_nxt;
            r_state      <= w_state_nxt;
            r_irq        <= w_irq_nxt;
            r_missed     <= w_missed_nxt;
            r_fire_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_shadow_nxt = r_shadow_low;
        w_cmp_nxt    = r_cmp;
        w_valid_nxt  = r_cmp_valid;
        w_state_nxt  = r_state;
        w_irq_nxt    = r_irq;
        w_missed_nxt = r_missed;
        w_cnt_nxt    = r_fire_cnt;
        w_fire       = 1'b0;

        if (ALARM_CMP_LOW_WEN)
            w_shadow_nxt = ALARM_CMP_LOW;

        // Commit registers load even while disabled; only the state differs.
        if (ALARM_CMP_HIGH_WEN) begin
            w_cmp_nxt   = {ALARM_CMP_HIGH, w_low_eff};
            w_valid_nxt = 1'b1;
            w_cnt_nxt   = '0;
        end

        if (!ALARM_ENABLE) begin
            w_state_nxt  = ST_IDLE;
            w_irq_nxt    = 1'b0;
            w_missed_nxt = 1'b0;
        end else if (ALARM_CMP_HIGH_WEN) begin
            // Match against the old cmp is discarded this cycle.
            w_state_nxt = ST_ARMED;
        end else begin
            unique case (r_state)
                ST_IDLE:  if (r_cmp_valid) w_state_nxt = ST_ARMED;
                ST_ARMED: begin
                    if (w_match) begin
                        w_fire    = 1'b1;
                        w_irq_nxt = 1'b1;
                        if (ALARM_PERIODIC && r_irq)
                            w_missed_nxt = 1'b1;
                        if (r_fire_cnt != '1)
                            w_cnt_nxt = r_fire_cnt + 1'b1;
                        if (w_reload)
                            w_cmp_nxt = w_reload_cmp;
                        else
                            w_state_nxt = ST_FIRED;
                    end
                end
                ST_FIRED: ;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end

        // ACK loses to a fire in the same cycle.
        if (ALARM_ENABLE && ALARM_ACK && !w_fire) begin
            w_irq_nxt    = 1'b0;
            w_missed_nxt = 1'b0;
        end
    end

    assign ALARM_IRQ      = r_irq;
    assign ALARM_MISSED   = r_missed;
    assign ALARM_FIRE_CNT = r_fire_cnt;
    assign ALARM_STATE    = r_state;
endmodule
